rptr_ctrl_fwft: RTL and testbench

//  Read-domain pointer controller for the dual-clock async FIFO; next generation of the read-pointer logic.

---
 rtl/rptr_ctrl_fwft.sv | 121 ++++++++++++
 tb/tb_rptr_ctrl_fwft.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rptr_ctrl_fwft.sv
// Read-domain pointer controller for the dual-clock FIFO: binary/Gray read pointer,
// RAM read strobe/address, registered status flags, and standard or FWFT presentation.
module rptr_ctrl_fwft #(
    parameter int ASIZE     = 3,
    parameter int AE_THRESH = 1,
    parameter bit FWFT      = 1'b0
) (
    input  logic             rdclk,
    input  logic             in_resetn,
    input  logic             in_rd_en,
    input  logic [ASIZE:0]   sync_wptr_gray,
    output logic [ASIZE:0]   rptr_gray,
    output logic [ASIZE-1:0] rptr_binary_addr,
    output logic             ram_rd_en,
    output logic             out_valid,
    output logic             out_empty,
    output logic             out_almost_empty,
    output logic [ASIZE:0]   rd_count,
    output logic             out_underflow
);

    localparam int PW = ASIZE + 1;
    localparam logic [PW-1:0] AE_LIM = AE_THRESH[PW-1:0];

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rptr_bin_r;
    logic [PW-1:0] rptr_gray_r;
    logic          mem_empty_r;
    logic          out_valid_r;
    logic          out_empty_r;
    logic          out_ae_r;
    logic [PW-1:0] rd_count_r;
    logic          out_underflow_r;

    logic          ram_rd_en_s;
    logic [PW-1:0] rptr_bin_nxt_s;
    logic [PW-1:0] rptr_gray_nxt_s;
    logic          mem_empty_nxt_s;
    logic [PW-1:0] count_nxt_s;
    logic          out_valid_nxt_s;
    logic          out_empty_nxt_s;
    logic          underflow_nxt_s;

    // Read strobe, next pointer, and next flag values for the selected read mode
    always_comb begin
        ram_rd_en_s     = 1'b0;
        out_valid_nxt_s = 1'b0;
        out_empty_nxt_s = 1'b1;
        underflow_nxt_s = 1'b0;
        if (FWFT) begin
            // Prefetch into an idle output register, or refill as the consumer takes the word
            ram_rd_en_s = ~mem_empty_r & (~out_valid_r | in_rd_en);
        end else begin
            ram_rd_en_s = in_rd_en & ~mem_empty_r;
        end
        rptr_bin_nxt_s  = rptr_bin_r + {{ASIZE{1'b0}}, ram_rd_en_s};
        rptr_gray_nxt_s = bin2gray(rptr_bin_nxt_s);
        mem_empty_nxt_s = (rptr_gray_nxt_s == sync_wptr_gray);
        count_nxt_s     = gray2bin(sync_wptr_gray) - rptr_bin_nxt_s;
        if (FWFT) begin
            if (ram_rd_en_s) begin
                out_valid_nxt_s = 1'b1;
            end else if (in_rd_en) begin
                out_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s = out_valid_r;
            end
            out_empty_nxt_s = ~out_valid_nxt_s;
            underflow_nxt_s = in_rd_en & ~out_valid_r;
        end else begin
            out_valid_nxt_s = ram_rd_en_s;
            out_empty_nxt_s = mem_empty_nxt_s;
            underflow_nxt_s = in_rd_en & mem_empty_r;
        end
    end

    // Pointer and status registers
    always_ff @(posedge rdclk or negedge in_resetn) begin
        if (!in_resetn) begin
            rptr_bin_r      <= {PW{1'b0}};
            rptr_gray_r     <= {PW{1'b0}};
            mem_empty_r     <= 1'b1;
            out_valid_r     <= 1'b0;
            out_empty_r     <= 1'b1;
            out_ae_r        <= 1'b1;
            rd_count_r      <= {PW{1'b0}};
            out_underflow_r <= 1'b0;
        end else begin
            rptr_bin_r      <= rptr_bin_nxt_s;
            rptr_gray_r     <= rptr_gray_nxt_s;
            mem_empty_r     <= mem_empty_nxt_s;
            out_valid_r     <= out_valid_nxt_s;
            out_empty_r     <= out_empty_nxt_s;
            out_ae_r        <= (count_nxt_s <= AE_LIM);
            rd_count_r      <= count_nxt_s;
            out_underflow_r <= underflow_nxt_s;
        end
    end

    assign rptr_gray        = rptr_gray_r;
    assign rptr_binary_addr = rptr_bin_r[ASIZE-1:0];
    assign ram_rd_en        = ram_rd_en_s;
    assign out_valid        = out_valid_r;
    assign out_empty        = out_empty_r;
    assign out_almost_empty = out_ae_r;
    assign rd_count         = rd_count_r;
    assign out_underflow    = out_underflow_r;

endmodule

// File: tb/tb_rptr_ctrl_fwft.sv
// Randomized bench for rptr_ctrl_fwft: one standard-mode and one FWFT-mode instance,
// each checked against an integer word-count model of the FIFO read side.
module tb_rptr_ctrl_fwft;

    localparam int ASIZE = 3;
    localparam int DEPTH = 8;
    localparam int AE    = 1;

    logic             rdclk;
    logic             in_resetn;
    logic [1:0]       rd_en_s;
    logic [1:0][3:0]  wptr_s;
    logic [1:0][3:0]  rgray_s;
    logic [1:0][2:0]  addr_s;
    logic [1:0]       ram_rd_s;
    logic [1:0]       valid_s;
    logic [1:0]       empty_s;
    logic [1:0]       ae_s;
    logic [1:0][3:0]  count_s;
    logic [1:0]       uf_s;

    int n_cmp = 0;
    int n_bad = 0;

    // model: total words written / read from RAM, plus consumer-visible state
    int w_m[2];
    int r_m[2];
    bit me_m[2];
    bit v_m[2];
    bit e_m[2];
    bit uf_m[2];

    rptr_ctrl_fwft #(.ASIZE(ASIZE), .AE_THRESH(AE), .FWFT(1'b0)) dut0 (
        .rdclk(rdclk), .in_resetn(in_resetn), .in_rd_en(rd_en_s[0]),
        .sync_wptr_gray(wptr_s[0]), .rptr_gray(rgray_s[0]), .rptr_binary_addr(addr_s[0]),
        .ram_rd_en(ram_rd_s[0]), .out_valid(valid_s[0]), .out_empty(empty_s[0]),
        .out_almost_empty(ae_s[0]), .rd_count(count_s[0]), .out_underflow(uf_s[0])
    );

    rptr_ctrl_fwft #(.ASIZE(ASIZE), .AE_THRESH(AE), .FWFT(1'b1)) dut1 (
        .rdclk(rdclk), .in_resetn(in_resetn), .in_rd_en(rd_en_s[1]),
        .sync_wptr_gray(wptr_s[1]), .rptr_gray(rgray_s[1]), .rptr_binary_addr(addr_s[1]),
        .ram_rd_en(ram_rd_s[1]), .out_valid(valid_s[1]), .out_empty(empty_s[1]),
        .out_almost_empty(ae_s[1]), .rd_count(count_s[1]), .out_underflow(uf_s[1])
    );

    initial rdclk = 1'b0;
    always #5 rdclk = ~rdclk;

    function automatic int gray_of(input int n);
        int x;
        x = n % (2 * DEPTH);
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input int m);
        check($sformatf("m%0d rptr_gray", m), int'(rgray_s[m]), gray_of(r_m[m]));
        check($sformatf("m%0d rd_count", m), int'(count_s[m]), w_m[m] - r_m[m]);
        check($sformatf("m%0d almost_empty", m), int'(ae_s[m]), int'((w_m[m] - r_m[m]) <= AE));
        check($sformatf("m%0d out_valid", m), int'(valid_s[m]), int'(v_m[m]));
        check($sformatf("m%0d out_empty", m), int'(empty_s[m]), int'(e_m[m]));
        check($sformatf("m%0d underflow", m), int'(uf_s[m]), int'(uf_m[m]));
    endtask

    // one rdclk cycle: drive, check the strobe, advance the model across the edge
    task automatic step(input bit rd0, input bit rd1);
        bit rd[2];
        bit fire[2];
        bit nv[2];
        rd[0] = rd0;
        rd[1] = rd1;
        rd_en_s = {rd1, rd0};
        for (int m = 0; m < 2; m++) wptr_s[m] = 4'(gray_of(w_m[m]));
        #1;
        for (int m = 0; m < 2; m++) begin
            if (m == 1) fire[m] = (w_m[m] != r_m[m]) && !me_m[m] && (!v_m[m] || rd[m]);
            else        fire[m] = !me_m[m] && rd[m];
            check($sformatf("m%0d ram_rd_en", m), int'(ram_rd_s[m]), int'(fire[m]));
            if (fire[m]) check($sformatf("m%0d addr", m), int'(addr_s[m]), r_m[m] % DEPTH);
        end
        @(posedge rdclk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (m == 1) begin
                nv[m]   = fire[m] ? 1'b1 : (rd[m] ? 1'b0 : v_m[m]);
                uf_m[m] = rd[m] && !v_m[m];
                e_m[m]  = !nv[m];
            end else begin
                nv[m]   = fire[m];
                uf_m[m] = rd[m] && me_m[m];
            end
            v_m[m] = nv[m];
            r_m[m] = r_m[m] + int'(fire[m]);
            me_m[m] = (r_m[m] == w_m[m]);
            if (m == 0) e_m[m] = me_m[m];
            check_regs(m);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            w_m[m] = 0; r_m[m] = 0;
            me_m[m] = 1'b1; v_m[m] = 1'b0; e_m[m] = 1'b1; uf_m[m] = 1'b0;
        end
    endtask

    // asynchronous reset between clock edges; outputs must clear immediately
    task automatic async_reset();
        @(negedge rdclk);
        #2;
        in_resetn = 1'b0;
        rd_en_s = 2'b00;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            check_regs(m);
            check($sformatf("m%0d ram_rd_en in reset", m), int'(ram_rd_s[m]), 0);
        end
        wptr_s = '0;
        @(negedge rdclk);
        in_resetn = 1'b1;
        @(posedge rdclk);
        #1;
    endtask

    initial begin
        in_resetn = 1'b0;
        rd_en_s = 2'b00;
        wptr_s = '0;
        model_reset();
        repeat (2) @(posedge rdclk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check_regs(m);
            check($sformatf("m%0d ram_rd_en reset", m), int'(ram_rd_s[m]), 0);
        end
        @(negedge rdclk);
        in_resetn = 1'b1;
        @(posedge rdclk);
        #1;

        // standard mode: four words, four reads
        w_m[0] = 4;
        step(1'b0, 1'b0);
        check("t2 count4", int'(count_s[0]), 4);
        repeat (4) step(1'b1, 1'b0);
        check("t2 empty after 4", int'(empty_s[0]), 1);
        step(1'b0, 1'b0);

        // FWFT: one word falls through and is held until consumed
        w_m[1] = 1;
        repeat (3) step(1'b0, 1'b0);
        check("t3 fwft valid held", int'(valid_s[1]), 1);
        step(1'b0, 1'b1);
        check("t3 fwft empty after consume", int'(empty_s[1]), 1);

        // reads on an empty FIFO in both modes
        step(1'b1, 1'b1);
        check("t5 underflow m0", int'(uf_s[0]), 1);
        check("t5 underflow m1", int'(uf_s[1]), 1);
        step(1'b0, 1'b0);

        // random traffic through several pointer wraps, alternating fill-heavy and drain-heavy phases
        for (int c = 0; c < 600; c++) begin
            bit rdr[2];
            int lvl;
            lvl = ((c / 50) % 2 == 0) ? 3 : 1;
            for (int m = 0; m < 2; m++) begin
                if ((w_m[m] - r_m[m] < DEPTH) && ($urandom_range(0, 3) < 2)) w_m[m] = w_m[m] + 1;
                rdr[m] = ($urandom_range(0, 3) >= lvl);
            end
            step(rdr[0], rdr[1]);
        end

        async_reset();

        // full depth from rptr = 0
        w_m[0] = DEPTH;
        w_m[1] = DEPTH;
        step(1'b0, 1'b0);
        check("t6 full count m0", int'(count_s[0]), 8);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        async_reset();
        step(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
